// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a small fall-through byte FIFO.
// Output handshake: a byte transfers on a rising clk edge where o_valid && i_ready;
// o_data holds the FIFO head and stays stable while o_valid=1 and i_ready=0.
module uart_rx_monitor #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overflow,
   output logic       o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        rx_meta_q, rx_s_q;
   logic        busy_q;
   logic        frame_err_q, frame_err_d;
   logic        overflow_q, overflow_d;
   logic        push_req;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_empty, fifo_full, do_push, do_pop;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receiver state, counters and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         busy_q      <= (state_d != IDLE);
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // Next-state logic: mid-bit sampling, LSB-first shift, stop-bit check.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      push_req    = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == HALF_LAST) begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end
         end
         DATA: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == BIT_LAST) begin
               shreg_d = {rx_s_q, shreg_q[7:1]};
               cnt_d   = '0;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  push_req = 1'b1;
                  state_d  = IDLE;
               end else begin
                  // Stop bit low: drop the byte and wait out any break condition.
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop     = !fifo_empty && i_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push    = push_req && (!fifo_full || do_pop);
   assign overflow_d = push_req && fifo_full && !do_pop;

   // FIFO pointers; they carry one extra wrap bit to tell full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage; contents need no reset since o_valid gates them.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
   end

   assign o_data      = mem_q[rd_ptr_q[AW-1:0]];
   assign o_valid     = !fifo_empty;
   assign o_frame_err = frame_err_q;
   assign o_overflow  = overflow_q;
   assign o_busy      = busy_q;

endmodule
